// File: rtl/pim_alu_pkg.sv
// pim_alu_pkg: shared definitions for the PIM vector ALU.
// Holds the opcode width and the opcode enumeration shared by the lane
// datapath and the vector top.
package pim_alu_pkg;

  localparam int ALU_OP_WIDTH = 3;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MIN  = 3'b101,
    OP_MAX  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

endpackage

// File: rtl/pim_alu_lane.sv
// pim_alu_lane: combinational single-lane ALU with accumulation stage.
// Ports:
//   a, b      - lane operands
//   op        - opcode
//   acc       - current lane accumulator value
//   acc_en    - select accumulated value as the lane result
//   acc_clr   - treat the accumulator as zero for this beat
//   res       - lane result (ALU result or accumulated value)
//   carry     - carry/borrow of the ALU op, or carry of the accumulation add
//   acc_next  - accumulator value this beat would write when acc_en is set
module pim_alu_lane
  import pim_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  carry,
  output logic [DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic [DATA_WIDTH-1:0] acc_base;
  logic [DATA_WIDTH:0]   acc_sum;

  // Opcode decode, then the optional accumulation add on top of the ALU result.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is set exactly when unsigned a < b.
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = a;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[DATA_WIDTH-1:0];
        alu_carry = diff[DATA_WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_MIN:  alu_res = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  alu_res = ($signed(a) < $signed(b)) ? b : a;
      OP_PASS: alu_res = a;
      default: alu_res = a;
    endcase

    acc_base = acc_clr ? {DATA_WIDTH{1'b0}} : acc;
    acc_sum  = {1'b0, acc_base} + {1'b0, alu_res};
    acc_next = acc_sum[DATA_WIDTH-1:0];

    if (acc_en) begin
      res   = acc_sum[DATA_WIDTH-1:0];
      carry = acc_sum[DATA_WIDTH];
    end else begin
      res   = alu_res;
      carry = alu_carry;
    end
  end

endmodule

// File: rtl/pim_vec_alu.sv
// pim_vec_alu: multi-lane pipelined PIM ALU with per-lane accumulators.
// One registered output stage with valid/ready on both sides.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid, in_ready   - operand beat handshake
//   op, acc_en, acc_clr  - per-beat control, shared by all lanes
//   a, b                 - packed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid, out_ready - result beat handshake
//   result, carry, zero  - registered packed lane results and per-lane flags
module pim_vec_alu
  import pim_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ALU_OP_WIDTH-1:0]     op,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] result,
  output logic [LANES-1:0]            carry,
  output logic [LANES-1:0]            zero
);

  logic [DATA_WIDTH-1:0] acc       [LANES];
  logic [DATA_WIDTH-1:0] lane_res  [LANES];
  logic [DATA_WIDTH-1:0] lane_next [LANES];
  logic [LANES-1:0]      lane_carry;
  logic                  accept;

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pim_alu_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .a        (a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b        (b[i*DATA_WIDTH +: DATA_WIDTH]),
      .op       (alu_op_e'(op)),
      .acc      (acc[i]),
      .acc_en   (acc_en),
      .acc_clr  (acc_clr),
      .res      (lane_res[i]),
      .carry    (lane_carry[i]),
      .acc_next (lane_next[i])
    );
  end

  // Output register and valid flag: load on accept, drop valid on a drain-only cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {(LANES*DATA_WIDTH){1'b0}};
      carry     <= {LANES{1'b0}};
      zero      <= {LANES{1'b0}};
    end else if (accept) begin
      out_valid <= 1'b1;
      carry     <= lane_carry;
      for (int i = 0; i < LANES; i++) begin
        result[i*DATA_WIDTH +: DATA_WIDTH] <= lane_res[i];
        zero[i] <= (lane_res[i] == {DATA_WIDTH{1'b0}});
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-lane accumulators: written only by accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) acc[i] <= {DATA_WIDTH{1'b0}};
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (acc_en)       acc[i] <= lane_next[i];
        else if (acc_clr) acc[i] <= {DATA_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_pim_vec_alu.sv
// tb_pim_vec_alu: directed scoreboard bench for pim_vec_alu (DW=32, L=4).
module tb_pim_vec_alu;

  localparam int DW = 32;
  localparam int L  = 4;

  typedef struct packed {
    logic [L*DW-1:0] res;
    logic [L-1:0]    c;
    logic [L-1:0]    z;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            acc_en;
  logic            acc_clr;
  logic [L*DW-1:0] a;
  logic [L*DW-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [L*DW-1:0] result;
  logic [L-1:0]    carry;
  logic [L-1:0]    zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        q[$];
  logic [DW-1:0] macc [L];
  exp_t        last;
  logic [DW-1:0] rx_lane0[$];
  int          rx_cyc[$];

  pim_vec_alu #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference lane ALU: returns {carry/borrow, result}.
  function automatic logic [DW:0] ref_alu(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic signed [DW-1:0] sx, sy;
    sx = x; sy = y;
    case (o)
      3'd0: return {1'b0, x} + {1'b0, y};
      3'd1: return {(x < y), x - y};
      3'd2: return {1'b0, x & y};
      3'd3: return {1'b0, x | y};
      3'd4: return {1'b0, x ^ y};
      3'd5: return {1'b0, (sx < sy) ? x : y};
      3'd6: return {1'b0, (sx > sy) ? x : y};
      default: return {1'b0, x};
    endcase
  endfunction

  // Scoreboard monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed=%0h expected=none", result);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("scoreboard", {result, carry, zero}, e);
      end
      last = {result, carry, zero};
      rx_lane0.push_back(result[DW-1:0]);
      rx_cyc.push_back(cyc);
    end
  end

  // Present one beat, wait for acceptance, record the model's expectation.
  task automatic drive(input logic [2:0] o, input logic en, input logic clr,
                       input logic [L*DW-1:0] va, input logic [L*DW-1:0] vb);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; op = o; acc_en = en; acc_clr = clr; a = va; b = vb;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (in_ready) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready=%0b expected 1", in_ready);
    end
    for (int i = 0; i < L; i++) begin
      logic [DW:0] r;
      logic [DW:0] s;
      logic [DW-1:0] base;
      r = ref_alu(o, va[i*DW +: DW], vb[i*DW +: DW]);
      if (en) begin
        base = clr ? 32'd0 : macc[i];
        s = {1'b0, base} + {1'b0, r[DW-1:0]};
        e.res[i*DW +: DW] = s[DW-1:0];
        e.c[i] = s[DW];
        macc[i] = s[DW-1:0];
      end else begin
        e.res[i*DW +: DW] = r[DW-1:0];
        e.c[i] = r[DW];
        if (clr) macc[i] = 32'd0;
      end
      e.z[i] = (e.res[i*DW +: DW] == 32'd0);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Lane 0 directed, other lanes random.
  task automatic drive1(input logic [2:0] o, input logic en, input logic clr,
                        input logic [DW-1:0] a0, input logic [DW-1:0] b0);
    logic [L*DW-1:0] va, vb;
    for (int i = 1; i < L; i++) begin
      va[i*DW +: DW] = $urandom;
      vb[i*DW +: DW] = $urandom;
    end
    va[DW-1:0] = a0;
    vb[DW-1:0] = b0;
    drive(o, en, clr, va, vb);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic check_lane0(input string tag, input logic [DW-1:0] r0, input logic c0, input logic z0);
    drain();
    chk(tag, {last.res[DW-1:0], last.c[0], last.z[0]}, {r0, c0, z0});
  endtask

  initial begin
    int c0;
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; acc_en = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
    for (int i = 0; i < L; i++) macc[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_held_out_valid", out_valid, 1'b0);
    chk("reset_held_result", result, 128'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_result", {result, carry, zero}, 136'd0);
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Per-opcode directed values on lane 0.
    drive1(3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    check_lane0("add_wrap", 32'd0, 1'b1, 1'b1);
    drive1(3'd1, 1'b0, 1'b0, 32'd3, 32'd5);
    check_lane0("sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0);
    drive1(3'd5, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
    check_lane0("min_signed", 32'hFFFF_FFFE, 1'b0, 1'b0);
    drive1(3'd6, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
    check_lane0("max_signed", 32'd3, 1'b0, 1'b0);
    drive1(3'd2, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check_lane0("and", 32'h00F0_1234, 1'b0, 1'b0);
    drive1(3'd3, 1'b0, 1'b0, 32'hF000_0000, 32'h0000_000F);
    check_lane0("or", 32'hF000_000F, 1'b0, 1'b0);
    drive1(3'd4, 1'b0, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555);
    check_lane0("xor_zero", 32'd0, 1'b0, 1'b1);
    drive1(3'd7, 1'b0, 1'b0, 32'h1357_9BDF, 32'hFFFF_FFFF);
    check_lane0("pass", 32'h1357_9BDF, 1'b0, 1'b0);

    // Accumulate chain: 15 then 17 on consecutive cycles.
    drive1(3'd0, 1'b1, 1'b1, 32'd10, 32'd5);
    drive1(3'd0, 1'b1, 1'b0, 32'd1, 32'd1);
    drain();
    chk("acc_first", rx_lane0[rx_lane0.size()-2], 32'd15);
    chk("acc_second", rx_lane0[rx_lane0.size()-1], 32'd17);
    chk("acc_consecutive", rx_cyc[rx_cyc.size()-1] - rx_cyc[rx_cyc.size()-2], 1);

    // Clear without accumulate: plain output, accumulator zeroed.
    drive1(3'd0, 1'b0, 1'b1, 32'd4, 32'd4);
    check_lane0("clr_only_out", 32'd8, 1'b0, 1'b0);
    drive1(3'd0, 1'b1, 1'b0, 32'd2, 32'd3);
    check_lane0("after_clr_acc", 32'd5, 1'b0, 1'b0);

    // Backpressure: stall three cycles, then release with a new beat waiting.
    out_ready = 1'b0;
    drive1(3'd0, 1'b0, 1'b0, 32'd7, 32'd8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", {out_valid, result[DW-1:0]}, {1'b1, 32'd15});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive1(3'd1, 1'b0, 1'b0, 32'd100, 32'd1);
    check_lane0("after_stall", 32'd99, 1'b0, 1'b0);

    // Full throughput: 8 back-to-back beats, no bubbles.
    c0 = cyc;
    n0 = rx_lane0.size();
    for (int k = 0; k < 8; k++) begin
      logic [L*DW-1:0] va, vb;
      for (int i = 0; i < L; i++) begin
        va[i*DW +: DW] = $urandom;
        vb[i*DW +: DW] = $urandom;
      end
      drive(3'(k), 1'b0, 1'b0, va, vb);
    end
    chk("throughput_cycles", cyc - c0, 8);
    drain();
    chk("throughput_count", rx_lane0.size() - n0, 8);
    chk("throughput_spacing", rx_cyc[rx_cyc.size()-1] - rx_cyc[rx_cyc.size()-8], 7);

    // Reset mid-accumulate with a result in flight.
    drive1(3'd0, 1'b1, 1'b1, 32'd10, 32'd5);
    drive1(3'd0, 1'b1, 1'b0, 32'd1, 32'd1);
    check_lane0("pre_reset_acc", 32'd17, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive1(3'd0, 1'b1, 1'b0, 32'd2, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {out_valid, result, carry, zero}, 137'd0);
    q.delete();
    for (int i = 0; i < L; i++) macc[i] = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(3'd0, 1'b1, 1'b0, 128'd0, 128'd0);
    check_lane0("post_reset_acc", 32'd0, 1'b0, 1'b1);
    chk("post_reset_all", {last.res, last.z}, {128'd0, 4'hF});

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
